// File: rtl/datapath_mc.sv
// rtl/datapath_mc.sv - multicycle register-file/ALU/memory datapath
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   start                   instruction valid, sampled only while idle
//   RS1, RS2, RD            register indices
//   IMM                     signed immediate, used as operand B when ALUSrc=1
//   ALUControl              operation select
//   ALUSrc, MemRead, MemWrite, RegWrite, link   control bits
//   pclink                  value written to RD when link=1
//   busy, done              not-idle / write-back cycle indicators
//   Zero, Neg, Carry        flags registered with the ALU result
//   PCReg                   latched RS1 operand
//   mem_req, mem_we, mem_ack, Address, WriteData, ReadData   word memory port

module datapath_mc #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(NREGS)-1:0]  RS1,
    input  logic [$clog2(NREGS)-1:0]  RS2,
    input  logic [$clog2(NREGS)-1:0]  RD,
    input  logic [NBITS-1:0]          IMM,
    input  logic [WIDTH_ALUF-1:0]     ALUControl,
    input  logic                      ALUSrc,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      RegWrite,
    input  logic                      link,
    input  logic [NBITS-1:0]          pclink,
    output logic                      busy,
    output logic                      done,
    output logic                      Zero,
    output logic                      Neg,
    output logic                      Carry,
    output logic [NBITS-1:0]          PCReg,
    output logic                      mem_req,
    output logic                      mem_we,
    input  logic                      mem_ack,
    output logic [NBITS-1:2]          Address,
    output logic [NBITS-1:0]          WriteData,
    input  logic [NBITS-1:0]          ReadData
);

    localparam int IW = $clog2(NREGS);
    localparam int SW = $clog2(NBITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [WIDTH_ALUF-1:0] OP_SUB = WIDTH_ALUF'(4'b1000);
    localparam logic [WIDTH_ALUF-1:0] OP_AND = WIDTH_ALUF'(4'b0111);
    localparam logic [WIDTH_ALUF-1:0] OP_OR  = WIDTH_ALUF'(4'b0110);
    localparam logic [WIDTH_ALUF-1:0] OP_XOR = WIDTH_ALUF'(4'b0100);
    localparam logic [WIDTH_ALUF-1:0] OP_SLT = WIDTH_ALUF'(4'b0010);
    localparam logic [WIDTH_ALUF-1:0] OP_SLL = WIDTH_ALUF'(4'b0001);
    localparam logic [WIDTH_ALUF-1:0] OP_SRL = WIDTH_ALUF'(4'b0101);

    logic [1:0]            state_q, state_d;
    logic [NBITS-1:0]      regs_q [NREGS];
    logic [NBITS-1:0]      regs_d [NREGS];

    // operands and control captured when the instruction is accepted
    logic [NBITS-1:0]      a_q, a_d;
    logic [NBITS-1:0]      b_q, b_d;
    logic [NBITS-1:0]      sd_q, sd_d;
    logic [IW-1:0]         rd_q, rd_d;
    logic [WIDTH_ALUF-1:0] op_q, op_d;
    logic                  mr_q, mr_d;
    logic                  mw_q, mw_d;
    logic                  rw_q, rw_d;
    logic                  lk_q, lk_d;
    logic [NBITS-1:0]      pcl_q, pcl_d;

    logic [NBITS-1:0]      alu_q, alu_d;
    logic                  zero_q, zero_d;
    logic                  neg_q, neg_d;
    logic                  carry_q, carry_d;
    logic [NBITS-1:0]      rdata_q, rdata_d;

    logic [NBITS-1:0]      alu_res;
    logic                  alu_c;
    logic [NBITS:0]        sum;
    logic [SW-1:0]         shamt;
    logic [NBITS-1:0]      wb_data;
    logic [NBITS-1:0]      rs1_val;
    logic [NBITS-1:0]      rs2_val;

    // x0 is never written, the explicit guard keeps the read side honest too
    assign rs1_val = (RS1 == '0) ? '0 : regs_q[RS1];
    assign rs2_val = (RS2 == '0) ? '0 : regs_q[RS2];

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        shamt   = b_q[SW-1:0];
        alu_res = sum[NBITS-1:0];
        alu_c   = 1'b0;
        case (op_q)
            OP_SUB: begin
                alu_res = a_q - b_q;
                alu_c   = (a_q >= b_q);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SLT: alu_res = {{(NBITS-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLL: alu_res = a_q << shamt;
            OP_SRL: alu_res = a_q >> shamt;
            default: begin
                // ADD and every unassigned code
                alu_res = sum[NBITS-1:0];
                alu_c   = sum[NBITS];
            end
        endcase
    end

    // link beats load data beats ALU result
    always_comb begin
        if (lk_q)      wb_data = pcl_q;
        else if (mr_q) wb_data = rdata_q;
        else           wb_data = alu_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sd_d    = sd_q;
        rd_d    = rd_q;
        op_d    = op_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        rw_d    = rw_q;
        lk_d    = lk_q;
        pcl_d   = pcl_q;
        alu_d   = alu_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        rdata_d = rdata_q;
        regs_d  = regs_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = rs1_val;
                    b_d     = ALUSrc ? IMM : rs2_val;
                    sd_d    = rs2_val;
                    rd_d    = RD;
                    op_d    = ALUControl;
                    mr_d    = MemRead;
                    mw_d    = MemWrite;
                    rw_d    = RegWrite;
                    lk_d    = link;
                    pcl_d   = pclink;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d   = alu_res;
                zero_d  = (alu_res == '0);
                neg_d   = alu_res[NBITS-1];
                carry_d = alu_c;
                state_d = (mr_q || mw_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_ack) begin
                    rdata_d = ReadData;
                    state_d = S_WB;
                end
            end
            default: begin
                if (rw_q && (rd_q != '0)) begin
                    regs_d[rd_q] = wb_data;
                end
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            regs_q  <= '{default: '0};
            a_q     <= '0;
            b_q     <= '0;
            sd_q    <= '0;
            rd_q    <= '0;
            op_q    <= '0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            rw_q    <= 1'b0;
            lk_q    <= 1'b0;
            pcl_q   <= '0;
            alu_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sd_q    <= sd_d;
            rd_q    <= rd_d;
            op_q    <= op_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            rw_q    <= rw_d;
            lk_q    <= lk_d;
            pcl_q   <= pcl_d;
            alu_q   <= alu_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            rdata_q <= rdata_d;
        end
    end

    // memory outputs decode straight from state so reset drops them at once
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_WB);
    assign mem_req   = (state_q == S_MEM);
    assign mem_we    = mem_req & mw_q;
    assign Address   = mem_req ? alu_q[NBITS-1:2] : '0;
    assign WriteData = sd_q;
    assign PCReg     = a_q;
    assign Zero      = zero_q;
    assign Neg       = neg_q;
    assign Carry     = carry_q;

endmodule

// File: tb/tb_datapath_mc.sv
// tb/tb_datapath_mc.sv - scoreboard bench for datapath_mc

module tb_datapath_mc;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] RS1 = '0, RS2 = '0, RD = '0;
    logic [7:0] IMM = '0;
    logic [3:0] ALUControl = '0;
    logic       ALUSrc = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0, link = 1'b0;
    logic [7:0] pclink = '0;
    logic       busy, done, Zero, Neg, Carry;
    logic [7:0] PCReg;
    logic       mem_req, mem_we;
    logic       mem_ack;
    logic [7:2] Address;
    logic [7:0] WriteData;
    logic [7:0] ReadData = 8'hA5;
    logic       ack_r = 1'b0;
    logic       stray_ack = 1'b0;

    assign mem_ack = ack_r | stray_ack;

    datapath_mc #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
        .clock(clock), .reset(reset), .start(start),
        .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM), .ALUControl(ALUControl),
        .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .link(link), .pclink(pclink),
        .busy(busy), .done(done), .Zero(Zero), .Neg(Neg), .Carry(Carry),
        .PCReg(PCReg), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] wd;
        logic [7:0] res;
        logic       c;
        int         lat;
        bit         is_mem;
        int         memcyc;
        logic [5:0] addr;
        logic       we;
        int         scyc;
    } exp_t;

    exp_t q[$];
    int total  = 0;
    int passed = 0;
    int dones  = 0;
    int issued = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    // memory responder: acks on the (ack_delay+1)-th request cycle
    int         ack_delay = 0;
    int         rcnt = 0;
    logic       prev_req = 1'b0;
    logic [5:0] s_addr = '0;
    logic       s_we = 1'b0;
    logic [7:0] s_wd = '0;
    bit         unstable = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            ack_r    = 1'b0;
            rcnt     = 0;
            prev_req = 1'b0;
        end else begin
            if (mem_req) begin
                if (!prev_req) begin
                    rcnt     = 0;
                    s_addr   = Address;
                    s_we     = mem_we;
                    s_wd     = WriteData;
                    unstable = 1'b0;
                end else if (Address !== s_addr || mem_we !== s_we || WriteData !== s_wd) begin
                    unstable = 1'b1;
                end
                rcnt++;
                ack_r = (rcnt == ack_delay + 1);
            end else begin
                ack_r = 1'b0;
            end
            prev_req = mem_req;
        end
    end

    // monitor: every done cycle is matched against the oldest expectation
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset && done) begin
            dones++;
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 expected no pending instruction");
            end else begin
                e = q.pop_front();
                chk("zero",      Zero,      e.res == 8'h00);
                chk("neg",       Neg,       e.res[7]);
                chk("carry",     Carry,     e.c);
                chk("pcreg",     PCReg,     e.pc);
                chk("writedata", WriteData, e.wd);
                chk("latency",   cyc - e.scyc + 1, e.lat);
                chk("req_in_wb", mem_req,   1'b0);
                if (e.is_mem) begin
                    chk("mem_cycles", rcnt,     e.memcyc);
                    chk("mem_addr",   s_addr,   e.addr);
                    chk("mem_we",     s_we,     e.we);
                    chk("mem_stable", unstable, 1'b0);
                end
            end
        end
    end

    // call right after a rising edge; returns right after the edge that re-enters idle
    task automatic issue(input logic [4:0] rs1, rs2, rd, input logic [7:0] imm,
                         input logic [3:0] op, input bit src, mr, mw, rw, lk,
                         input logic [7:0] pcl, input logic [7:0] e_pc, e_wd, e_res,
                         input bit e_c, input int dly, input bit glitch);
        exp_t e;
        int   n;
        e.pc = e_pc; e.wd = e_wd; e.res = e_res; e.c = e_c;
        e.is_mem = mr | mw;
        e.lat    = (mr | mw) ? 4 + dly : 3;
        e.memcyc = dly + 1;
        e.addr   = e_res[7:2];
        e.we     = mw;
        ack_delay = dly;
        #1;
        e.scyc = cyc;
        q.push_back(e);
        RS1 = rs1; RS2 = rs2; RD = rd; IMM = imm; ALUControl = op;
        ALUSrc = src; MemRead = mr; MemWrite = mw; RegWrite = rw; link = lk; pclink = pcl;
        start = 1'b1;
        issued++;
        @(posedge clock); #1 start = 1'b0;
        if (glitch) begin
            RS1 = 5'd3; IMM = ~imm; start = 1'b1;
            @(posedge clock); #1 start = 1'b0;
        end
        n = 0;
        do begin
            @(posedge clock);
            n++;
        end while (q.size() != 0 && n < 60);
        if (q.size() != 0) begin
            total++;
            $display("FAIL timeout: got no done within %0d cycles expected done", n);
            q.delete();
        end
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_flags", {Zero, Neg, Carry}, 3'b000);
        chk("rst_mem", {mem_req, mem_we, Address}, 8'h00);
        chk("rst_wdata", WriteData, 8'h00);
        chk("rst_pcreg", PCReg, 8'h00);
        reset = 1'b1;
        @(posedge clock);
        //     rs1 rs2 rd imm    op  src mr mw rw lk pcl    pc     wd     res    c dly gl
        issue(0, 0, 1, 8'h7F, 4'h0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h7F, 0, 0, 0);
        issue(0, 0, 2, 8'h01, 4'h0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 0);
        issue(1, 2, 3, 8'h00, 4'h0, 0, 0, 0, 1, 0, 8'h00, 8'h7F, 8'h01, 8'h80, 0, 0, 0);
        issue(2, 2, 4, 8'h00, 4'h8, 0, 0, 0, 1, 0, 8'h00, 8'h01, 8'h01, 8'h00, 1, 0, 1);
        issue(2, 1, 5, 8'h00, 4'h8, 0, 0, 0, 1, 0, 8'h00, 8'h01, 8'h7F, 8'h82, 0, 0, 0);
        issue(3, 4, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h80, 8'h00, 8'h80, 0, 0, 0);
        issue(5, 0, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h82, 8'h00, 8'h82, 0, 0, 0);
        issue(3, 0, 0, 8'hC0, 4'h7, 1, 0, 0, 0, 0, 8'h00, 8'h80, 8'h00, 8'h80, 0, 0, 0);
        issue(3, 2, 0, 8'h00, 4'h6, 0, 0, 0, 0, 0, 8'h00, 8'h80, 8'h01, 8'h81, 0, 0, 0);
        issue(3, 0, 0, 8'h80, 4'h4, 1, 0, 0, 0, 0, 8'h00, 8'h80, 8'h00, 8'h00, 0, 0, 0);
        issue(3, 0, 0, 8'h01, 4'h2, 1, 0, 0, 0, 0, 8'h00, 8'h80, 8'h00, 8'h01, 0, 0, 0);
        issue(2, 0, 0, 8'h80, 4'h2, 1, 0, 0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
        issue(2, 0, 0, 8'h07, 4'h1, 1, 0, 0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h80, 0, 0, 0);
        issue(3, 0, 0, 8'h0B, 4'h5, 1, 0, 0, 0, 0, 8'h00, 8'h80, 8'h00, 8'h10, 0, 0, 0);
        issue(3, 0, 0, 8'h80, 4'hF, 1, 0, 0, 0, 0, 8'h00, 8'h80, 8'h00, 8'h00, 1, 0, 0);
        issue(1, 0, 0, 8'h81, 4'h0, 1, 0, 0, 0, 0, 8'h00, 8'h7F, 8'h00, 8'h00, 1, 0, 0);
        issue(0, 0, 1, 8'h10, 4'h0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 0);
        issue(1, 0, 7, 8'h04, 4'h0, 1, 1, 0, 1, 0, 8'h00, 8'h10, 8'h00, 8'h14, 0, 3, 0);
        issue(1, 3, 9, 8'h00, 4'h0, 1, 0, 1, 0, 0, 8'h00, 8'h10, 8'h80, 8'h10, 0, 0, 0);
        issue(7, 9, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 8'h00, 8'hA5, 0, 0, 0);
        issue(1, 1, 0, 8'h00, 4'h0, 0, 0, 0, 1, 0, 8'h00, 8'h10, 8'h10, 8'h20, 0, 0, 0);
        issue(1, 2, 8, 8'h00, 4'h0, 0, 0, 0, 1, 1, 8'h24, 8'h10, 8'h01, 8'h11, 0, 0, 0);
        issue(0, 8, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h24, 8'h24, 0, 0, 0);

        // load aborted by reset while waiting for mem_ack
        ack_delay = 10;
        #1;
        RS1 = 5'd1; RS2 = 5'd0; RD = 5'd10; IMM = 8'h00; ALUControl = 4'h0;
        ALUSrc = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; link = 1'b0;
        start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
        chk("req_before_reset", mem_req, 1'b1);
        reset = 1'b0;
        stray_ack = 1'b1;
        #1;
        chk("reset_mid_mem_req", mem_req, 1'b0);
        chk("reset_mid_mem_busy", busy, 1'b0);
        chk("reset_mid_mem_pc", PCReg, 8'h00);
        chk("reset_mid_mem_flags", {Zero, Neg, Carry, done}, 4'b0000);
        q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("stray_ack_idle", busy, 1'b0);
        stray_ack = 1'b0;
        @(posedge clock);
        issue(3, 7, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        issue(8, 1, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);

        repeat (3) @(posedge clock);
        #1;
        chk("done_count", dones, issued);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/datapath_mc.md
DATAPATH_MC -- requirements
Module: datapath_mc

Interface
Parameters
REQ-001 The block SHALL have parameter NBITS, default 8, datapath width.
REQ-002 The block SHALL have parameter NREGS, default 32, register-file depth; index width $clog2(NREGS).
REQ-003 The block SHALL have parameter WIDTH_ALUF, default 4, ALUControl width.

Ports
REQ-004 The block SHALL have port clock, input, 1, sole clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, instruction valid, sampled only in IDLE.
REQ-007 The block SHALL have ports RS1, RS2, RD, input, $clog2(NREGS) each, register indices.
REQ-008 The block SHALL have port IMM, input, NBITS, signed immediate.
REQ-009 The block SHALL have port ALUControl, input, WIDTH_ALUF, operation select.
REQ-010 The block SHALL have ports ALUSrc, MemRead, MemWrite, RegWrite, link, input, 1 each, control bits.
REQ-011 The block SHALL have port pclink, input, NBITS, value written to RD when link=1.
REQ-012 The block SHALL have ports busy and done, output, 1 each.
REQ-013 The block SHALL have ports Zero, Neg, Carry, output, 1 each, registered flags.
REQ-014 The block SHALL have port PCReg, output, NBITS, latched RS1 operand.
REQ-015 The block SHALL have ports mem_req and mem_we, output, 1 each, plus mem_ack, input, 1.
REQ-016 The block SHALL have ports Address, output, NBITS-1:2, WriteData, output, NBITS, and ReadData, input, NBITS.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC, MEM, WB; busy=1 in every state except IDLE.
REQ-018 In IDLE with start=1, the block SHALL latch regs[RS1], the operand B (IMM if ALUSrc, else regs[RS2]), regs[RS2] as store data, and all control inputs, then enter EXEC.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 EXEC SHALL register ALUResult and the flags, then enter MEM if MemRead|MemWrite, else WB.
REQ-021 ALU codes SHALL be: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0010 SLT (signed, result 1 or 0), 0001 SLL, 0101 SRL (shift amount B[$clog2(NBITS)-1:0]); any other code SHALL perform ADD.
REQ-022 Zero SHALL be (ALUResult==0) and Neg SHALL be ALUResult[NBITS-1].
REQ-023 Carry SHALL be the NBITS+1-bit carry-out for ADD, the not-borrow (A>=B unsigned) for SUB, and 0 for all other operations.
REQ-024 In MEM, the block SHALL hold mem_req=1, mem_we=MemWrite, Address=ALUResult[NBITS-1:2], and WriteData=latched RS2 stable until mem_ack is sampled high; it SHALL then capture ReadData and enter WB.
REQ-025 Outside MEM, mem_req SHALL be 0, mem_we 0, Address 0; WriteData SHALL remain the latched RS2 value.
REQ-026 WB SHALL last one cycle with done=1, then return to IDLE.
REQ-027 In WB, the register-file write data SHALL be selected with priority link > MemRead > ALU: pclink if link, else captured ReadData if MemRead, else ALUResult.
REQ-028 The register-file write in WB SHALL occur only if RegWrite=1 and RD!=0, and SHALL take effect at the WB-ending edge.
REQ-029 regs[0] SHALL always read as 0.
REQ-030 Latency: for a non-memory op with start at edge k, done SHALL be high in the cycle after edge k+2 and the write SHALL land at edge k+3; a memory op SHALL add one cycle plus the mem_ack wait cycles.
REQ-031 A new instruction started in the IDLE cycle after WB SHALL read the value written by the prior WB.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, clear every register-file entry and all latches to 0, and drive busy, done, Zero, Neg, Carry, mem_req, mem_we, Address, WriteData, and PCReg to 0, including mid-MEM.
REQ-033 A mem_ack arriving during reset or in any state other than MEM SHALL be ignored.

Verification
REQ-034 Verification SHALL cover: with NBITS=8, x1=0x7F and x2=0x01, ADD x3,x1,x2 -> x3=0x80, Neg=1, Zero=0, Carry=0, done 3 cycles after start.
REQ-035 Verification SHALL cover: SUB x4,x2,x2 -> x4=0, Zero=1, Carry=1; then SUB x5,x2,x1 -> x5=0x82, Carry=0, Neg=1.
REQ-036 Verification SHALL cover: a load with ALUSrc=1, x1=0x10, IMM=4, and mem_ack delayed 3 cycles -> mem_req high 4 cycles, Address=0x14>>2=5, RD=ReadData, done after ack.
REQ-037 Verification SHALL cover: a store with mem_ack immediate -> mem_we=1, WriteData=regs[RS2], and no register write.
REQ-038 Verification SHALL cover: RegWrite=1, RD=0 -> x0 stays 0; link=1, pclink=0x24 -> RD=0x24 regardless of ALU result.
REQ-039 Verification SHALL cover: reset=0 asserted in MEM -> mem_req=0 the same cycle, busy=0, and all registers 0; a start pulse during EXEC -> ignored.
